op_share_ctrl: RTL and testbench
================================

# op_share_ctrl

Two-requester round-robin arbiter and sequencer for the four-operation unit (BO + MYY: a+b, a*b, -a+b, -a). It latches one requester's operation code and operands, drives them to the unit, and issues the `sno` start pulse. It then waits for `sko`, captures the 2N-bit result and the result flags, and returns them to the winning requester. A watchdog aborts operations that never complete.

## Interface
Parameters:
- N, 4, operand width; must match the unit's N.
- TMO, 32, watchdog limit in WAIT cycles; 2..255.

Ports:
- clk  input  1  clock; all state changes on posedge.
- set  input  1  reset; one clock; reset is asynchronous and active-low.
- req0, req1  input  1 each  operation request from requester k; held high until `gnt_k`.
- cop0, cop1  input  2 each  operation code: 00 a+b, 01 a*b, 10 -a+b, 11 -a.
- a0, b0, a1, b1  input  N each  operands; valid while `req_k` is high.
- gnt0, gnt1  output  1 each  one-cycle grant pulse; operands have been latched.
- done0, done1  output  1 each  one-cycle completion pulse to the owner.
- err0, err1  output  1 each  valid with `done_k`; 1 = watchdog abort.
- res0, res1  output  2N each  result register per requester; holds its value until overwritten.
- flg0, flg1  output  4 each  {ovf, neg, pos, zero} per requester; updated together with `res_k`.
- u_sno  output  1  start pulse to the unit.
- u_cop  output  2  operation code to the unit.
- u_a, u_b  output  N each  operands to the unit.
- u_sko  input  1  end-of-operation from the unit.
- u_res  input  2N  unit result.
- u_flg  input  4  unit result flags.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE:**
  - If no request, stay in IDLE.
  - If any `req_k`, pick the winner: if both are high, the requester not served last wins; `last` resets to 1, so requester 0 wins first.
  - Latch the winner's cop/a/b into the u_* registers, record the owner, and go to ISSUE.
- **ISSUE (1 cycle):**
  - `u_sno`=1 and `gnt_owner`=1.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT:**
  - `u_sno`=0; u_cop/u_a/u_b held stable.
  - On `u_sko`=1 at an edge: capture `u_res`/`u_flg` into the owner's res/flg, set `err_owner`=0, go to DONE.
  - Otherwise the counter increments. When the counter reaches TMO-1 with no `u_sko`: go to DONE with `err_owner`=1, leaving res/flg unchanged.
- **DONE (1 cycle):**
  - `done_owner`=1.
  - `last` := owner.
  - Go to IDLE.
- `u_sko` is ignored in IDLE, ISSUE and DONE; it is treated as stale.
- Requests arriving while busy wait. A req still high at IDLE is a new request.
- u_* registers are not cleared after completion; they keep the last operands.
- Watchdog counter width is ceil(log2(TMO)); no wrap is possible because the abort comes first.

## Timing
- **Reset values (async, while `set`=0):**
  - state=IDLE, last=1.
  - All gnt/done/err/u_sno/busy = 0.
  - u_cop/u_a/u_b = 0; res/flg = 0.
  - Watchdog counter = 0.
- **Reset mid-operation:**
  - Immediate return to IDLE; no done pulse.
  - The unit must be reset by the same reset domain.
- **Request to start:** req sampled at edge E0 → gnt and `u_sno` high during the cycle after E0.
- **Completion:** `u_sko` sampled at edge Ek → `done_k` and the new `res_k` visible in the cycle after Ek. `busy` falls one cycle later.
- **Minimum occupancy:** 3 cycles (ISSUE, WAIT, DONE) plus the unit's latency.
- **Back-to-back with both requesting:** service alternates 0,1,0,1…, with one IDLE cycle between operations.
- **Simultaneous events:** new req edges during DONE are seen in IDLE the next cycle. A grant never goes to two requesters.

## Test plan
- **Single add:** N=4, req0 with cop=00, a=3, b=2; unit returns res=5, flg=0010 → gnt0 one cycle, u_sno one cycle, done0 with res0=5, flg0=0010, err0=0; res1 unchanged.
- **Simultaneous requests after reset:** req0 = a*b, 3*5; req1 = -a, a=4 → requester 0 served first (res0=15), then requester 1 (res1 = -4 sign-extended per the unit). Two done pulses, 0 then 1.
- **Fairness:** req0 and req1 held high continuously for 6 operations → grants alternate 0,1,0,1,0,1; no starvation.
- **Watchdog:** unit model never raises sko, TMO=32 → done0 with err0=1 exactly 32 cycles after ISSUE; res0 unchanged; next req1 served normally.
- **Reset mid-WAIT:** assert set=0 while in WAIT → busy=0, u_sno=0, no done; after release, req1 is granted and requester 0 retains priority (last=1).
- **Stale sko:** u_sko pulsed during ISSUE → ignored; completion occurs only on the later sko in WAIT.

Source files
------------

// File: rtl/op_share_ctrl.sv
// Two-requester round-robin front end for the four-operation unit: latches the
// winner's opcode/operands, pulses sno, waits for sko or a watchdog abort.
module op_share_ctrl #(
    parameter int N   = 4,
    parameter int TMO = 32
) (
    input  logic           clk,
    input  logic           set,
    input  logic           req0,
    input  logic           req1,
    input  logic [1:0]     cop0,
    input  logic [1:0]     cop1,
    input  logic [N-1:0]   a0,
    input  logic [N-1:0]   b0,
    input  logic [N-1:0]   a1,
    input  logic [N-1:0]   b1,
    output logic           gnt0,
    output logic           gnt1,
    output logic           done0,
    output logic           done1,
    output logic           err0,
    output logic           err1,
    output logic [2*N-1:0] res0,
    output logic [2*N-1:0] res1,
    output logic [3:0]     flg0,
    output logic [3:0]     flg1,
    output logic           u_sno,
    output logic [1:0]     u_cop,
    output logic [N-1:0]   u_a,
    output logic [N-1:0]   u_b,
    input  logic           u_sko,
    input  logic [2*N-1:0] u_res,
    input  logic [3:0]     u_flg,
    output logic           busy
);

    // state | meaning
    // IDLE  | no operation in flight, arbitrating pending requests
    // ISSUE | operands on the unit, sno and grant pulsed to the owner
    // WAIT  | waiting for sko, watchdog counting
    // DONE  | done (and err on abort) pulsed to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = $clog2(TMO);

    state_t         state;
    state_t         state_nxt;
    logic           owner;
    logic           last;
    logic           err_q;
    logic           pick;
    logic           wd_tc;
    logic [CW-1:0]  wd_cnt;

    // On a tie the requester not served last wins; otherwise the lone requester.
    assign pick  = (req0 && req1) ? ~last : req1;
    assign wd_tc = (wd_cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (u_sko || wd_tc) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        done0 = 1'b0;
        done1 = 1'b0;
        err0  = 1'b0;
        err1  = 1'b0;
        u_sno = 1'b0;
        busy  = (state != IDLE);
        case (state)
            ISSUE: begin
                u_sno = 1'b1;
                gnt0  = ~owner;
                gnt1  = owner;
            end
            DONE: begin
                done0 = ~owner;
                done1 = owner;
                err0  = ~owner & err_q;
                err1  = owner & err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge set) begin
        if (!set) begin
            owner  <= 1'b0;
            last   <= 1'b1;
            err_q  <= 1'b0;
            wd_cnt <= '0;
            u_cop  <= '0;
            u_a    <= '0;
            u_b    <= '0;
            res0   <= '0;
            res1   <= '0;
            flg0   <= '0;
            flg1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick;
                        u_cop <= pick ? cop1 : cop0;
                        u_a   <= pick ? a1 : a0;
                        u_b   <= pick ? b1 : b0;
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (u_sko) begin
                        err_q <= 1'b0;
                        if (owner) begin
                            res1 <= u_res;
                            flg1 <= u_flg;
                        end else begin
                            res0 <= u_res;
                            flg0 <= u_flg;
                        end
                    end else if (wd_tc) begin
                        err_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                end
                DONE: last <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_op_share_ctrl.sv
// Bench for op_share_ctrl: a behavioural four-operation unit with programmable
// latency, table vectors, random operations and multi-cycle corner sequences.
module tb_op_share_ctrl;

    localparam int N   = 4;
    localparam int TMO = 32;

    logic         clk = 1'b0;
    logic         set = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [1:0]   cop0 = '0, cop1 = '0;
    logic [3:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, done0, done1, err0, err1;
    logic [7:0]   res0, res1;
    logic [3:0]   flg0, flg1;
    logic         u_sno;
    logic [1:0]   u_cop;
    logic [3:0]   u_a, u_b;
    wire logic    u_sko;
    logic [7:0]   u_res;
    logic [3:0]   u_flg;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    op_share_ctrl #(.N(N), .TMO(TMO)) dut (
        .clk(clk), .set(set),
        .req0(req0), .req1(req1), .cop0(cop0), .cop1(cop1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .res0(res0), .res1(res1),
        .flg0(flg0), .flg1(flg1),
        .u_sno(u_sno), .u_cop(u_cop), .u_a(u_a), .u_b(u_b),
        .u_sko(u_sko), .u_res(u_res), .u_flg(u_flg),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic of the unit: signed N-bit operands, signed 2N-bit result.
    function automatic logic [7:0] calc_res(input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
        int sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (c)
            2'd0:    r = sa + sb;
            2'd1:    r = sa * sb;
            2'd2:    r = sb - sa;
            default: r = -sa;
        endcase
        return r[7:0];
    endfunction

    function automatic logic [3:0] calc_flg(input logic [7:0] r);
        return {1'b0, r[7], (!r[7] && r != 8'd0), (r == 8'd0)};
    endfunction

    // Unit model: answers sko unit_lat cycles after sno; result changes even on a hang.
    int   unit_lat  = 1;
    bit   unit_kill = 1'b0;
    logic unit_sko;
    logic inj_sko = 1'b0;
    int   ucnt;
    bit   uact;
    assign u_sko = unit_sko | inj_sko;

    always @(posedge clk or negedge set) begin
        if (!set) begin
            uact     <= 1'b0;
            ucnt     <= 0;
            unit_sko <= 1'b0;
            u_res    <= '0;
            u_flg    <= '0;
        end else begin
            unit_sko <= 1'b0;
            if (u_sno) begin
                uact  <= 1'b1;
                ucnt  <= unit_lat;
                u_res <= calc_res(u_cop, u_a, u_b);
                u_flg <= calc_flg(calc_res(u_cop, u_a, u_b));
            end else if (uact) begin
                if (ucnt <= 1) begin
                    uact     <= 1'b0;
                    unit_sko <= !unit_kill;
                end else begin
                    ucnt <= ucnt - 1;
                end
            end
        end
    end

    logic [7:0] m_res [2];
    logic [3:0] m_flg [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_req(input bit who, input logic [1:0] c, input logic [3:0] a, input logic [3:0] b);
        if (who) begin
            req1 = 1'b1; cop1 = c; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; cop0 = c; a0 = a; b0 = b;
        end
    endtask

    task automatic check_regs();
        chk("res0", res0, m_res[0]);
        chk("res1", res1, m_res[1]);
        chk("flg0", flg0, m_flg[0]);
        chk("flg1", flg1, m_flg[1]);
    endtask

    // One isolated operation from IDLE; checks grant, unit drive, latency and result.
    task automatic run_op(input bit who, input logic [1:0] c, input logic [3:0] a, input logic [3:0] b,
                          input int lat, input bit kill, input bit stale,
                          input logic [7:0] exp_res, input logic [3:0] exp_flg);
        bit got;
        int dly;
        unit_lat  = lat;
        unit_kill = kill;
        drive_req(who, c, a, b);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = gnt0 | gnt1;
        end
        chk("gnt_seen", got, 1);
        chk("gnt_who", {gnt1, gnt0}, who ? 2'b10 : 2'b01);
        chk("u_sno", u_sno, 1);
        chk("u_ops", {u_cop, u_a, u_b}, {c, a, b});
        req0 = 1'b0;
        req1 = 1'b0;
        if (stale) inj_sko = 1'b1;
        got = 1'b0;
        dly = 0;
        for (int i = 1; i <= TMO + 10 && !got; i++) begin
            @(negedge clk);
            inj_sko = 1'b0;
            if (done0 | done1) begin
                got = 1'b1;
                dly = i;
            end
        end
        chk("done_seen", got, 1);
        chk("done_lat", dly, kill ? TMO + 1 : lat + 2);
        chk("done_who", {done1, done0}, who ? 2'b10 : 2'b01);
        chk("err", who ? err1 : err0, kill);
        if (!kill) begin
            m_res[who] = exp_res;
            m_flg[who] = exp_flg;
        end
        check_regs();
        @(negedge clk);
        chk("busy_after", busy, 0);
    endtask

    typedef struct {
        bit         who;
        logic [1:0] cop;
        logic [3:0] a;
        logic [3:0] b;
        int         lat;
        logic [7:0] exp_res;
        logic [3:0] exp_flg;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] rc;
        logic [3:0] ra, rb;
        bit         rw;
        bit         got;
        int         gap;
        int         lat_r;

        tbl[0] = '{0, 2'd0, 4'd3, 4'd2, 3, 8'h05, 4'b0010};
        tbl[1] = '{1, 2'd1, 4'd3, 4'd5, 1, 8'h0F, 4'b0010};
        tbl[2] = '{0, 2'd2, 4'd3, 4'd2, 2, 8'hFF, 4'b0100};
        tbl[3] = '{1, 2'd3, 4'd4, 4'd0, 1, 8'hFC, 4'b0100};
        tbl[4] = '{0, 2'd0, 4'hD, 4'd3, 5, 8'h00, 4'b0001};
        tbl[5] = '{1, 2'd1, 4'hE, 4'd7, 2, 8'hF2, 4'b0100};
        tbl[6] = '{0, 2'd1, 4'h8, 4'h8, 1, 8'h40, 4'b0010};
        tbl[7] = '{1, 2'd2, 4'h8, 4'd7, 4, 8'h0F, 4'b0010};
        tbl[8] = '{0, 2'd3, 4'h8, 4'd0, 1, 8'h08, 4'b0010};
        tbl[9] = '{1, 2'd0, 4'd7, 4'd7, 6, 8'h0E, 4'b0010};

        m_res[0] = '0; m_res[1] = '0;
        m_flg[0] = '0; m_flg[1] = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {gnt0, gnt1, done0, done1, err0, err1, u_sno}, 0);
        chk("rst_uops", {u_cop, u_a, u_b}, 0);
        check_regs();
        set = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        for (int k = 0; k < 10; k++)
            run_op(tbl[k].who, tbl[k].cop, tbl[k].a, tbl[k].b, tbl[k].lat, 1'b0, 1'b0,
                   tbl[k].exp_res, tbl[k].exp_flg);

        // Watchdog abort, then a normal operation from the other side.
        run_op(0, 2'd0, 4'd1, 4'd1, 1, 1'b1, 1'b0, 8'h00, 4'b0000);
        run_op(1, 2'd0, 4'd2, 4'd3, 2, 1'b0, 1'b0, 8'h05, 4'b0010);

        // Stray sko while idle, then sko during ISSUE; only the real one completes.
        inj_sko = 1'b1;
        @(negedge clk);
        inj_sko = 1'b0;
        chk("stale_idle_busy", busy, 0);
        run_op(0, 2'd0, 4'd6, 4'd1, 4, 1'b0, 1'b1, 8'h07, 4'b0010);

        for (int k = 0; k < 20; k++) begin
            rw    = 1'($urandom_range(0, 1));
            rc    = 2'($urandom_range(0, 3));
            ra    = 4'($urandom_range(0, 15));
            rb    = 4'($urandom_range(0, 15));
            lat_r = $urandom_range(1, 6);
            run_op(rw, rc, ra, rb, lat_r, 1'b0, 1'b0, calc_res(rc, ra, rb), calc_flg(calc_res(rc, ra, rb)));
        end

        // Reset in the middle of WAIT.
        unit_kill = 1'b1;
        drive_req(0, 2'd0, 4'd1, 4'd2);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = gnt0;
        end
        chk("mid_gnt", got, 1);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy_wait", busy, 1);
        set = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pulses", {u_sno, done0, done1, gnt0, gnt1}, 0);
        m_res[0] = '0; m_res[1] = '0;
        m_flg[0] = '0; m_flg[1] = '0;
        check_regs();
        @(negedge clk);
        chk("mid_no_done", {done0, done1}, 0);
        set = 1'b1;
        unit_kill = 1'b0;

        // Both requesters held high: 0 first after reset, then strict alternation.
        unit_lat = 2;
        drive_req(0, 2'd1, 4'd3, 4'd5);
        drive_req(1, 2'd3, 4'd4, 4'd0);
        for (int k = 0; k < 6; k++) begin
            got = 1'b0;
            gap = 0;
            for (int i = 1; i <= 8 && !got; i++) begin
                @(negedge clk);
                if (gnt0 | gnt1) begin
                    got = 1'b1;
                    gap = i;
                end
            end
            chk("fair_gnt_seen", got, 1);
            chk("fair_gnt_who", {gnt1, gnt0}, (k % 2) ? 2'b10 : 2'b01);
            chk("fair_gap", gap, (k == 0) ? 1 : 2);
            got = 1'b0;
            for (int i = 1; i <= TMO + 10 && !got; i++) begin
                @(negedge clk);
                got = done0 | done1;
            end
            chk("fair_done_who", {done1, done0, err1, err0}, (k % 2) ? 4'b1000 : 4'b0100);
            if (k % 2) begin
                m_res[1] = 8'hFC; m_flg[1] = 4'b0100;
            end else begin
                m_res[0] = 8'h0F; m_flg[0] = 4'b0010;
            end
            check_regs();
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
